// File: rtl/exc_arbiter.sv
// exc_arbiter: commit-stage exception/interrupt arbiter for the dual-issue pipeline.
// It picks one event per trigger and holds the fetch redirect until fetch accepts it.
module exc_arbiter #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int INT_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        s0_valid,
    input  logic        s1_valid,
    input  logic [31:0] s0_pc,
    input  logic [31:0] s1_pc,
    input  logic        s0_bd,
    input  logic        s1_bd,
    input  logic [6:0]  s0_cause,
    input  logic [6:0]  s1_cause,
    input  logic [31:0] s0_badvaddr,
    input  logic [31:0] s1_badvaddr,
    input  logic        s0_eret,
    input  logic        s1_eret,
    input  logic [5:0]  ext_int,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    output logic        exc_valid,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_epc,
    output logic        exc_bd,
    output logic [31:0] exc_badvaddr,
    output logic        eret_out,
    output logic [5:0]  hw_ip,
    output logic        kill_s1,
    output logic        kill_s0,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        commit_stall
);
    localparam logic IDLE = 1'b0;
    localparam logic REDIR = 1'b1;

    logic state;
    logic [5:0] sync_q [INT_SYNC_STAGES];
    logic int_pend_q, int_req;
    logic [31:0] redir_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < INT_SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= ext_int;
            for (int i = 1; i < INT_SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign hw_ip = sync_q[INT_SYNC_STAGES-1];
    assign int_req = cp0_status[0] & ~cp0_status[1] &
                     (|({hw_ip, cp0_cause[9:8]} & cp0_status[15:8]) | (cp0_cause[30] & cp0_status[15]));

    // A lone slot1 is promoted to the slot0 position ("a"); "b" is the younger slot.
    logic        a_v, b_v, a_int, a_ret, a_hit, sel_b, trig, is_exc, is_eret, bd;
    logic [6:0]  a_c, c;
    logic [31:0] a_pc, a_bva, pc, bva;
    logic [4:0]  code;

    assign a_v   = s0_valid | s1_valid;
    assign b_v   = s0_valid & s1_valid;
    assign a_c   = s0_valid ? s0_cause : (s1_valid ? s1_cause : 7'd0);
    assign a_ret = s0_valid ? s0_eret : (s1_valid & s1_eret);
    assign a_pc  = s0_valid ? s0_pc : s1_pc;
    assign a_bva = s0_valid ? s0_badvaddr : s1_badvaddr;
    assign a_int = int_pend_q & a_v;
    assign a_hit = a_int | (|a_c) | a_ret;
    assign sel_b = b_v & ~a_hit & ((|s1_cause) | s1_eret);
    assign trig  = resetn & (state == IDLE) & (a_hit | sel_b);

    assign c   = sel_b ? s1_cause : a_c;
    assign pc  = sel_b ? s1_pc : a_pc;
    assign bva = sel_b ? s1_badvaddr : a_bva;
    assign bd  = sel_b ? s1_bd : (s0_valid ? s0_bd : s1_bd);

    assign is_exc  = trig & (a_int | (|c));
    assign is_eret = trig & ~is_exc;

    assign code = a_int ? 5'd0  : c[6] ? 5'd4 : c[5] ? 5'd10 : c[4] ? 5'd12 :
                  c[3]  ? 5'd8  : c[2] ? 5'd9 : c[1] ? 5'd4  : 5'd5;

    assign exc_valid    = is_exc;
    assign exc_code     = is_exc ? code : 5'd0;
    assign exc_epc      = is_exc ? (bd ? pc - 32'd4 : pc) : 32'd0;
    assign exc_bd       = is_exc & bd;
    assign exc_badvaddr = is_exc ? ((c[6] & ~a_int) ? pc : bva) : 32'd0;
    assign eret_out     = is_eret;
    assign kill_s0      = is_exc & ~sel_b;
    assign kill_s1      = is_exc | (is_eret & ~sel_b);
    assign redirect_valid = state == REDIR;
    assign redirect_pc    = redir_q;
    assign commit_stall   = trig | (state == REDIR);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            redir_q    <= '0;
            int_pend_q <= 1'b0;
        end else begin
            int_pend_q <= int_req;
            if (trig) begin
                state   <= REDIR;
                redir_q <= is_exc ? EXC_VECTOR : cp0_epc;
            end else if (state == REDIR && redirect_ready) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_exc_arbiter.sv
// tb_exc_arbiter: directed checks of exc_arbiter against hand-computed expectations.
module tb_exc_arbiter;
    logic        clk = 0;
    logic        resetn;
    logic        s0_valid, s1_valid, s0_bd, s1_bd, s0_eret, s1_eret, redirect_ready;
    logic [31:0] s0_pc, s1_pc, s0_badvaddr, s1_badvaddr, cp0_status, cp0_cause, cp0_epc;
    logic [6:0]  s0_cause, s1_cause;
    logic [5:0]  ext_int, hw_ip;
    logic        exc_valid, exc_bd, eret_out, kill_s1, kill_s0, redirect_valid, commit_stall;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc, exc_badvaddr, redirect_pc;
    int checks = 0;
    int errors = 0;

    exc_arbiter dut (
        .clk(clk), .resetn(resetn),
        .s0_valid(s0_valid), .s1_valid(s1_valid), .s0_pc(s0_pc), .s1_pc(s1_pc),
        .s0_bd(s0_bd), .s1_bd(s1_bd), .s0_cause(s0_cause), .s1_cause(s1_cause),
        .s0_badvaddr(s0_badvaddr), .s1_badvaddr(s1_badvaddr),
        .s0_eret(s0_eret), .s1_eret(s1_eret), .ext_int(ext_int),
        .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_epc(exc_epc), .exc_bd(exc_bd),
        .exc_badvaddr(exc_badvaddr), .eret_out(eret_out), .hw_ip(hw_ip),
        .kill_s1(kill_s1), .kill_s0(kill_s0), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_ready(redirect_ready), .commit_stall(commit_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        s0_valid = 0; s1_valid = 0; s0_bd = 0; s1_bd = 0; s0_eret = 0; s1_eret = 0;
        s0_pc = 0; s1_pc = 0; s0_cause = 0; s1_cause = 0; s0_badvaddr = 0; s1_badvaddr = 0;
    endtask

    task automatic release_redir();
        redirect_ready = 1;
        tick();
        redirect_ready = 0;
        chk("redir_released", redirect_valid, 0);
    endtask

    initial begin
        clear();
        resetn = 0; ext_int = 0; cp0_status = 0; cp0_cause = 0; cp0_epc = 0; redirect_ready = 0;
        tick(); tick();
        chk("rst_exc_valid", exc_valid, 0);
        chk("rst_redir_valid", redirect_valid, 0);
        chk("rst_stall", commit_stall, 0);
        chk("rst_redir_pc", redirect_pc, 0);
        chk("rst_hw_ip", hw_ip, 0);
        resetn = 1;
        // slot0 overflow
        s0_valid = 1; s0_pc = 32'h8000_0010; s0_cause = 7'b0010000;
        s1_valid = 1; s1_pc = 32'h8000_0014;
        #1;
        chk("ov_valid", exc_valid, 1);
        chk("ov_code", exc_code, 12);
        chk("ov_epc", exc_epc, 32'h8000_0010);
        chk("ov_kill_s0", kill_s0, 1);
        chk("ov_kill_s1", kill_s1, 1);
        chk("ov_stall", commit_stall, 1);
        tick(); clear(); #1;
        chk("ov_pulse_once", exc_valid, 0);
        chk("ov_redir_valid", redirect_valid, 1);
        chk("ov_redir_pc", redirect_pc, 32'hBFC0_0380);
        chk("ov_redir_stall", commit_stall, 1);
        release_redir();
        // slot0 clean, slot1 syscall in delay slot
        s0_valid = 1; s0_pc = 32'h8000_0020;
        s1_valid = 1; s1_pc = 32'h8000_0024; s1_bd = 1; s1_cause = 7'b0001000;
        #1;
        chk("sys_code", exc_code, 8);
        chk("sys_epc", exc_epc, 32'h8000_0020);
        chk("sys_bd", exc_bd, 1);
        chk("sys_kill_s0", kill_s0, 0);
        chk("sys_kill_s1", kill_s1, 1);
        tick(); clear();
        release_redir();
        // slot0 eret beats slot1 ri
        s0_valid = 1; s0_eret = 1; s0_pc = 32'h8000_0030; cp0_epc = 32'h8000_1000;
        s1_valid = 1; s1_cause = 7'b0100000;
        #1;
        chk("eret_out", eret_out, 1);
        chk("eret_exc_valid", exc_valid, 0);
        chk("eret_kill_s1", kill_s1, 1);
        chk("eret_kill_s0", kill_s0, 0);
        tick(); clear(); #1;
        chk("eret_redir_pc", redirect_pc, 32'h8000_1000);
        chk("eret_pulse_once", eret_out, 0);
        release_redir();
        // slot0 fetch address error: BadVAddr is the PC
        s0_valid = 1; s0_pc = 32'h8000_0101; s0_badvaddr = 32'h1234_5678; s0_cause = 7'b1000000;
        #1;
        chk("ifadel_code", exc_code, 4);
        chk("ifadel_bva", exc_badvaddr, 32'h8000_0101);
        tick(); clear();
        release_redir();
        // slot1 store address error
        s0_valid = 1; s0_pc = 32'h8000_0200;
        s1_valid = 1; s1_pc = 32'h8000_0204; s1_badvaddr = 32'h0000_0102; s1_cause = 7'b0000001;
        #1;
        chk("ades_code", exc_code, 5);
        chk("ades_bva", exc_badvaddr, 32'h0000_0102);
        chk("ades_epc", exc_epc, 32'h8000_0204);
        tick(); clear();
        release_redir();
        // interrupt: IE=1, EXL=0, IM2=1, ext_int[0]
        cp0_status = 32'h0000_0401; ext_int = 6'b000001;
        tick(); tick();
        chk("int_hw_ip", hw_ip, 6'b000001);
        s0_valid = 1; s0_pc = 32'h8000_0300;
        #1;
        chk("int_not_yet", exc_valid, 0);
        tick();
        chk("int_valid", exc_valid, 1);
        chk("int_code", exc_code, 0);
        chk("int_epc", exc_epc, 32'h8000_0300);
        chk("int_kill_s0", kill_s0, 1);
        ext_int = 0; cp0_status = 0;
        tick(); clear();
        release_redir();
        tick(); tick();
        // EXL masks interrupts
        cp0_status = 32'h0000_0403; ext_int = 6'b000001;
        tick(); tick(); tick(); tick();
        s0_valid = 1; s0_pc = 32'h8000_0400;
        #1;
        chk("exl_no_int", exc_valid, 0);
        ext_int = 0; cp0_status = 0; clear();
        tick(); tick(); tick(); tick();
        // redirect held while ready low; a pending bp waits
        s0_valid = 1; s0_eret = 1; s0_pc = 32'h8000_0500; cp0_epc = 32'h8000_2000;
        tick(); clear();
        s0_valid = 1; s0_pc = 32'h8000_0600; s0_cause = 7'b0000100;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_redir_pc", redirect_pc, 32'h8000_2000);
            chk("hold_no_exc", exc_valid, 0);
            tick();
        end
        redirect_ready = 1;
        #1;
        chk("hold_last_no_exc", exc_valid, 0);
        tick();
        redirect_ready = 0;
        #1;
        chk("bp_taken", exc_valid, 1);
        chk("bp_code", exc_code, 9);
        tick(); clear(); #1;
        chk("bp_redir_pc", redirect_pc, 32'hBFC0_0380);
        chk("bp_redir_valid", redirect_valid, 1);
        // reset during REDIR
        resetn = 0;
        tick();
        chk("rstr_redir_valid", redirect_valid, 0);
        chk("rstr_stall", commit_stall, 0);
        chk("rstr_redir_pc", redirect_pc, 0);
        chk("rstr_exc_valid", exc_valid, 0);
        resetn = 1;
        tick();
        chk("rstr_idle", redirect_valid, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/exc_arbiter.md
Name: exc_arbiter

Overview:
- Exception/interrupt controller for the dual-issue commit stage; sequences the CP0 register file.
- Each cycle, collects exception causes and ERET from the two commit slots: slot0 is older, slot1 is younger.
- Also samples hardware, software and timer interrupts.
- Selects one event, issues a single-cycle exception record to CP0 and kills younger work.
- Redirects fetch to the exception vector or EPC through a valid/ready handshake, stalling commit until fetch accepts.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, fetch target for all exceptions and interrupts.
- INT_SYNC_STAGES, 2, synchronizer depth for ext_int.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low
- s0_valid, s1_valid  in  1 each  slot holds a committing instruction
- s0_pc, s1_pc  in  32 each  instruction PC
- s0_bd, s1_bd  in  1 each  instruction is in a branch delay slot
- s0_cause, s1_cause  in  7 each  one-hot {if_adel, ri, ov, sys, bp, adel, ades}
- s0_badvaddr, s1_badvaddr  in  32 each  faulting address, for if_adel/adel/ades
- s0_eret, s1_eret  in  1 each  slot is ERET
- ext_int  in  6  asynchronous hardware interrupt lines
- cp0_status  in  32  current Status (IE=bit0, EXL=bit1, IM=bits15:8)
- cp0_cause  in  32  current Cause (IP1:0 = bits9:8, TI = bit30)
- cp0_epc  in  32  current EPC
- exc_valid  out  1  exception record valid; drives CP0 exception_en
- exc_code  out  5  ExcCode
- exc_epc  out  32  EPC to record
- exc_bd  out  1  BD to record
- exc_badvaddr  out  32  BadVAddr to record
- eret_out  out  1  ERET commit pulse to CP0
- hw_ip  out  6  synchronized ext_int, for Cause.IP7:2
- kill_s1  out  1  squash slot1 this cycle
- kill_s0  out  1  squash slot0 writeback (slot0 excepted)
- redirect_valid  out  1  fetch redirect request
- redirect_pc  out  32  redirect target
- redirect_ready  in  1  fetch accepted redirect
- commit_stall  out  1  hold commit stage

Behaviour:
- Reset: every output is 0, FSM=IDLE, synchronizer cleared.
- Interrupt sampling
  - ext_int passes through INT_SYNC_STAGES flops; the last stage is hw_ip.
  - int_req = IE & ~EXL & |({hw_ip, cp0_cause[9:8]} & IM[7:2..0] mapping) | (TI & IM[7]).
  - int_req is registered once (int_pend_q); the interrupt is taken from int_pend_q.
- Trigger evaluation, IDLE only, combinational in the same cycle:
  - Priority: slot0 before slot1.
  - For slot0: interrupt (int_pend_q & s0_valid) > if_adel > ri > ov > sys > bp > adel > ades > eret.
  - slot1 is considered only if slot0 is valid with no cause/eret; slot1 gets no interrupt.
  - Codes: Int=0, AdEL=4 (if_adel and adel), AdES=5, Sys=8, Bp=9, RI=10, Ov=12.
- Exception selected on slot k
  - exc_valid=1 for exactly one cycle.
  - exc_epc = bd ? pc-4 : pc; exc_bd = bd.
  - exc_badvaddr = pc for if_adel, otherwise sk_badvaddr.
  - kill_s0 = (k==0); kill_s1=1.
  - Latch redirect_pc=EXC_VECTOR; go to REDIR.
  - Interrupt is on slot0: kill_s0=1, EPC=s0_pc (the instruction is not executed).
- ERET selected on slot k
  - eret_out=1 for one cycle; latch redirect_pc=cp0_epc.
  - kill_s1=1 if k==0; go to REDIR.
- REDIR state
  - redirect_valid=1 and commit_stall=1.
  - redirect_pc is held stable until redirect_valid & redirect_ready, then go to IDLE.
  - While in REDIR, no new trigger is evaluated; exc_valid/eret_out stay 0.
- Combinational kill/pulses appear only in the trigger cycle; commit_stall is also 1 in the trigger cycle.
- Exception with EXL=1: record is still issued (CP0 ignores the update); redirect still goes to EXC_VECTOR.
- Slot1 valid without slot0 valid: not allowed; treat slot1 as slot0 anyway (no stall).
- resetn low in REDIR: immediate IDLE, redirect dropped.
- Implementation: 2-state FSM (IDLE, REDIR) plus redirect_pc/int_pend_q/synchronizer registers.

Test Plan:
- s0 ov, pc=0x8000_0010, bd=0 -> exc_valid 1 cycle, code=12, epc=0x8000_0010, kill_s0=kill_s1=1; redirect_valid until ready; redirect_pc=0xBFC0_0380.
- s0 clean, s1 sys, pc=0x8000_0024, bd=1 -> code=8, epc=0x8000_0020, bd=1, kill_s0=0, kill_s1=1.
- s0 eret, cp0_epc=0x8000_1000, s1 ri -> eret_out=1, exc_valid=0, kill_s1=1, redirect_pc=0x8000_1000.
- IE=1, EXL=0, IM[2]=1, ext_int[0] raised -> after sync+1 cycles, next valid s0 gets code=0, epc=s0_pc; with EXL=1, no interrupt.
- redirect_ready low 5 cycles while a new s0 bp is presented -> redirect held stable, no second exc_valid; the bp is taken only after return to IDLE.
- resetn asserted during REDIR -> next cycle all outputs 0, state IDLE.
